// File: rtl/ifetch_queue.sv
// Instruction fetch front end: a fetch PC plus a 2-entry {pc, inst} queue with redirect and sticky fault.
// Optional macro IFETCH_BOUND_CHECK_EN faults any enqueue attempt beyond the last MEM_BYTES word.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam int unsigned XW = 32;

  typedef struct packed {
    logic [XW-1:0] pc;
    logic [XW-1:0] inst;
  } entry_t;

  if (MEM_BYTES < 32'd4) begin : g_mem_check
    $error("ifetch_queue: MEM_BYTES must hold at least one word");
  end

  logic [XW-1:0] pc_q, pc_d;
  entry_t        e0_q, e0_d, e1_q, e1_d;
  logic          v0_q, v0_d, v1_q, v1_d;
  logic          fault_q, fault_d;
  logic          acc_deq, attempt, enq, over;

`ifdef IFETCH_BOUND_CHECK_EN
  localparam logic [XW-1:0] LAST_ADDR = XW'(MEM_BYTES - 32'd4);
`endif

  // Next-state: redirect wins over deq/enqueue; a fault freezes everything until reset.
  always_comb begin
    pc_d    = pc_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    fault_d = fault_q;
    acc_deq = deq & v0_q;
    attempt = ~v1_q | acc_deq;
    over    = 1'b0;
    enq     = 1'b0;
`ifdef IFETCH_BOUND_CHECK_EN
    over = pc_q > LAST_ADDR;
`endif
    if (!fault_q) begin
      if (redirect) begin
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        pc_d    = redirect_pc;
        fault_d = |redirect_pc[1:0];
      end else begin
        if (acc_deq) begin
          e0_d = e1_q;
          v0_d = v1_q;
          v1_d = 1'b0;
        end
        if (attempt && over) begin
          fault_d = 1'b1;
          v0_d    = 1'b0;
          v1_d    = 1'b0;
        end
        enq = attempt & ~over;
        if (enq) begin
          if (!v0_d) begin
            e0_d = '{pc: pc_q, inst: inst};
            v0_d = 1'b1;
          end else begin
            e1_d = '{pc: pc_q, inst: inst};
            v1_d = 1'b1;
          end
          pc_d = pc_q + XW'(4);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      e0_q    <= '0;
      e1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      fault_q <= fault_d;
    end
  end

  assign inst_addr = pc_q;
  assign out_valid = v0_q;
  assign out_pc    = e0_q.pc;
  assign out_inst  = e0_q.inst;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: vector table plus an alternating-deq ordering sequence.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        deq = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fault;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [1024];

  ifetch_queue #(.RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst(inst),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {mem[b], mem[10'(b + 10'd1)], mem[10'(b + 10'd2)], mem[10'(b + 10'd3)]};
  endfunction

  assign inst = word(inst_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        redirect;
    logic [31:0] rpc;
    logic        deq;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic        chk_data;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    int nexp;
    int accepted;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    mem[0] = 8'h20; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h20; mem[5] = 8'h02; mem[6] = 8'h00; mem[7] = 8'h07;

    //          rst   redir rpc       deq   valid addr      pc        inst          fault chk
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'h4,   32'h2002_0007, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   32'h8,   32'h0809_0A0B, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   32'h4,   32'h2002_0007, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  32'h8,   32'h0809_0A0B, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  32'hC,   32'h0C0D_0E0F, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h40,  1'b1, 1'b0, 32'h40,  32'h0,   32'h0,        1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  32'h40,  32'h4041_4243, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h48,  32'h44,  32'h4445_4647, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 32'h42,  1'b1, 1'b0, 32'h42,  32'h0,   32'h0,        1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 32'h0,   1'b1, 1'b0, 32'h42,  32'h0,   32'h0,        1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h42,  32'h0,   32'h0,        1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 1'b1, 32'h40,  1'b1, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   32'h0,   32'h2001_0005, 1'b0, 1'b1};
    vecs[24] = '{1'b0, 1'b1, 32'h3FC, 1'b1, 1'b0, 32'h3FC, 32'h0,   32'h0,        1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'h3FC, 32'hFCFD_FEFF, 1'b0, 1'b1};
`ifdef IFETCH_BOUND_CHECK_EN
    vecs[26] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h400, 32'h0,   32'h0,        1'b1, 1'b0};
`else
    vecs[26] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h404, 32'h400, 32'h2001_0005, 1'b0, 1'b1};
`endif

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      deq         = vecs[i].deq;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d inst_addr", i), inst_addr, vecs[i].addr);
      check($sformatf("v%0d fault", i), 32'(fault), 32'(vecs[i].fault));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
        check($sformatf("v%0d out_inst", i), out_inst, vecs[i].inst);
      end
    end

    // Alternating deq: accepted heads must be 0,4,8,... with no gaps or repeats.
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; deq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nexp = 0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      deq = (i % 2) == 1;
      if (deq && out_valid) begin
        check($sformatf("alt%0d out_pc", i), out_pc, 32'(nexp));
        check($sformatf("alt%0d out_inst", i), out_inst, word(32'(nexp)));
        nexp += 4;
        accepted++;
      end
    end
    check("alt accepted count", 32'(accepted), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter MEM_BYTES, default 1024: size of the byte-addressed instruction memory being fetched from.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inst_addr  output  32  byte address driven to instruction memory; equals the internal fetch PC, registered, no combinational path from inputs.
REQ-006 inst  input  32  big-endian instruction word returned combinationally by memory for inst_addr, valid in the same cycle.
REQ-007 redirect  input  1  load a new fetch PC and flush the queue.
REQ-008 redirect_pc  input  32  target byte address, sampled when redirect=1.
REQ-009 deq  input  1  consumer accepts the head entry this cycle; ignored when out_valid=0.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_inst  output  32  head instruction word.
REQ-012 out_pc  output  32  byte address the head instruction was fetched from.
REQ-013 fault  output  1  sticky fetch fault flag.

Function
REQ-014 Queue is a 2-entry FIFO of {pc, inst} pairs; out_* reflect the oldest entry, driven from registers.
REQ-015 Enqueue occurs on a rising edge when no redirect, fault=0, and (count<2 or an accepted deq in the same cycle); entry = {inst_addr, inst}; fetch PC then advances by 4 (32-bit wrap).
REQ-016 Accepted deq (deq=1 and out_valid=1) removes the head on the same edge; simultaneous enqueue and deq at count=2 keeps count=2, FIFO order preserved.
REQ-017 deq with out_valid=0 has no effect.
REQ-018 Full (count=2) and no deq: fetch PC holds, inst ignored, no entry lost or duplicated.
REQ-019 Steady-state throughput with deq held high: one instruction per cycle, consecutive out_pc values differ by 4.
REQ-020 redirect=1 (priority over deq and enqueue): queue emptied, inst this cycle discarded, fetch PC <= redirect_pc; out_valid=0 next cycle, first target instruction valid the cycle after.
REQ-021 redirect with redirect_pc[1:0]!=0: fault<=1, queue flushed, fetch PC <= redirect_pc; no further enqueues until reset.
REQ-022 While fault=1: redirect ignored, deq ignored, out_valid=0.
REQ-023 Latency: instruction at address A is presented on out_* exactly one cycle after inst_addr=A when the queue is not full.

Reset
REQ-024 On rising edge with rst=1: fetch PC=RESET_PC, count=0, out_valid=0, out_inst=0, out_pc=0, fault=0; rst overrides redirect and deq.
REQ-025 Reset asserted mid-stream discards all queued entries; first cycle after deassertion inst_addr=RESET_PC, out_valid=0; next cycle out_valid=1 with out_pc=RESET_PC.

Configuration
REQ-026 Macro IFETCH_BOUND_CHECK_EN defined: an enqueue attempt with inst_addr > MEM_BYTES-4 instead sets fault=1 and enqueues nothing; a redirect to such an address sets fault on the next enqueue attempt.
REQ-027 Macro IFETCH_BOUND_CHECK_EN undefined: no range check; fault set only by misaligned redirect; addresses beyond MEM_BYTES fetched unchanged.

Verification
REQ-028 Reset, memory bytes 0..7 = 20 01 00 05 20 02 00 07, deq=1 -> cycle 1 out_pc=0 out_inst=32'h2001_0005, cycle 2 out_pc=4 out_inst=32'h2002_0007.
REQ-029 deq=0 for 5 cycles after reset -> count saturates at 2, inst_addr holds at 8, head remains pc 0; deq=1 then yields pc 0,4,8 on consecutive cycles, no gaps or duplicates.
REQ-030 redirect=1 redirect_pc=32'h40 with 2 queued entries and deq=1 -> next cycle out_valid=0, inst_addr=32'h40; following cycle out_pc=32'h40.
REQ-031 redirect_pc=32'h42 -> fault=1 next cycle, out_valid=0, later redirect to 32'h0 ignored, rst clears fault and restarts at RESET_PC.
REQ-032 With IFETCH_BOUND_CHECK_EN, MEM_BYTES=1024, redirect to 32'h3FC, deq=1 -> out_pc=32'h3FC delivered, then fault=1 with inst_addr=32'h400 and no entry for 32'h400; without macro, 32'h400 enqueued and fault stays 0.
REQ-033 rst=1 asserted with redirect=1 and count=2 -> next cycle count=0, inst_addr=RESET_PC, fault=0.
